// File: rtl/can_arbiter_n.sv
// can_arbiter_n
// CAN-style bitwise arbitration between N_NODES nodes, each with an ID_W-bit
// identifier. The identifiers are shifted out MSB first onto a modelled
// wired-AND bus, where 0 is dominant and 1 is recessive. Any node that sends
// recessive while the bus reads dominant drops out of arbitration. After ID_W
// bit-times the surviving node(s) and the received identifier are reported.
//
// Ports:
//   clk       rising-edge system clock
//   rst       synchronous active-high reset, returns the block to IDLE
//   load      starts arbitration; only sampled in IDLE, and only when req != 0
//   req       per-node participation mask, latched together with load
//   ids       packed identifiers, node i = ids[i*ID_W +: ID_W]
//   bus_bit   current wired-AND bus level (1 outside ARB)
//   busy      high in ARB and DONE
//   active    nodes still in arbitration (reads 0 outside ARB)
//   done      one-cycle pulse when winner/data/collision are valid
//   winner    surviving node(s); more than one bit set on a collision
//   data      identifier received from the bus
//   collision more than one node survived all ID_W bits
module can_arbiter_n #(
  parameter int N_NODES = 2,
  parameter int ID_W    = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic [N_NODES-1:0]      req,
  input  logic [N_NODES*ID_W-1:0] ids,
  output logic                    bus_bit,
  output logic                    busy,
  output logic [N_NODES-1:0]      active,
  output logic                    done,
  output logic [N_NODES-1:0]      winner,
  output logic [ID_W-1:0]         data,
  output logic                    collision
);

  localparam int CW = (ID_W > 2) ? $clog2(ID_W) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARB  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [ID_W-1:0]    shreg [N_NODES];
  logic [N_NODES-1:0] act_q;
  logic [N_NODES-1:0] act_nxt;
  logic [N_NODES-1:0] msb;
  logic [CW-1:0]      cnt;
  logic [ID_W-1:0]    data_q;
  logic [N_NODES-1:0] winner_q;
  logic               coll_q;
  logic               start;
  logic               last_bit;

  assign start    = (state == IDLE) && load && (req != '0);
  assign last_bit = (state == ARB) && (cnt == '0);

  // Wired-AND bus: only nodes still in arbitration pull the bus; a node that
  // has dropped out behaves as recessive.
  always_comb begin
    bus_bit = 1'b1;
    act_nxt = '0;
    for (int i = 0; i < N_NODES; i++) begin
      msb[i] = shreg[i][ID_W-1];
    end
    if (state == ARB) begin
      for (int i = 0; i < N_NODES; i++) begin
        if (act_q[i]) begin
          bus_bit = bus_bit & msb[i];
        end
      end
    end
    for (int i = 0; i < N_NODES; i++) begin
      act_nxt[i] = act_q[i] & (msb[i] == bus_bit);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = ARB;
      ARB:     if (cnt == '0) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: latch on start, shift every ARB bit, capture the result on the
  // last bit so winner/collision are valid in the DONE cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      act_q    <= '0;
      cnt      <= '0;
      data_q   <= '0;
      winner_q <= '0;
      coll_q   <= 1'b0;
      for (int i = 0; i < N_NODES; i++) begin
        shreg[i] <= '0;
      end
    end else if (start) begin
      act_q    <= req;
      cnt      <= CW'(ID_W - 1);
      data_q   <= '0;
      winner_q <= '0;
      coll_q   <= 1'b0;
      for (int i = 0; i < N_NODES; i++) begin
        shreg[i] <= ids[i*ID_W +: ID_W];
      end
    end else if (state == ARB) begin
      act_q  <= act_nxt;
      cnt    <= cnt - CW'(1);
      data_q <= {data_q[ID_W-2:0], bus_bit};
      for (int i = 0; i < N_NODES; i++) begin
        shreg[i] <= {shreg[i][ID_W-2:0], 1'b0};
      end
      if (last_bit) begin
        winner_q <= act_nxt;
        // x & (x-1) is nonzero exactly when more than one bit is set
        coll_q   <= (act_nxt & (act_nxt - N_NODES'(1))) != '0;
      end
    end
  end

  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign active    = (state == ARB) ? act_q : '0;
  assign winner    = winner_q;
  assign data      = data_q;
  assign collision = coll_q;

endmodule

// File: tb/tb_can_arbiter_n.sv
// tb_can_arbiter_n
// Directed bench for can_arbiter_n. Two instances are used: a 2-node/8-bit
// arbiter for most scenarios and a 4-node/8-bit arbiter for the wider case.
// Expected values are hand-derived from the identifier bit patterns.
module tb_can_arbiter_n;

  logic        clk;
  logic        rst;

  logic        load2;
  logic [1:0]  req2;
  logic [15:0] ids2;
  logic        bus2, busy2, done2, coll2;
  logic [1:0]  act2, win2;
  logic [7:0]  data2;

  logic        load4;
  logic [3:0]  req4;
  logic [31:0] ids4;
  logic        bus4, busy4, done4, coll4;
  logic [3:0]  act4, win4;
  logic [7:0]  data4;

  int compared;
  int mismatched;

  can_arbiter_n #(.N_NODES(2), .ID_W(8)) u2 (
    .clk(clk), .rst(rst), .load(load2), .req(req2), .ids(ids2),
    .bus_bit(bus2), .busy(busy2), .active(act2), .done(done2),
    .winner(win2), .data(data2), .collision(coll2)
  );

  can_arbiter_n #(.N_NODES(4), .ID_W(8)) u4 (
    .clk(clk), .rst(rst), .load(load4), .req(req4), .ids(ids4),
    .bus_bit(bus4), .busy(busy4), .active(act4), .done(done4),
    .winner(win4), .data(data4), .collision(coll4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock and settle just after the edge, away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One-cycle load pulse on the 2-node arbiter; afterwards ids/req are
  // scrambled to show the latched copy is what gets arbitrated.
  task automatic applyStimulus(input logic [1:0] req, input logic [15:0] ids);
    load2 = 1'b1;
    req2  = req;
    ids2  = ids;
    tick();
    load2 = 1'b0;
    req2  = 2'b00;
    ids2  = 16'h0000;
  endtask

  // Walk the 8 bit-times checking the bus level, and the active mask right
  // after bit chk_bit has been consumed. Ends in the DONE cycle.
  task automatic runArb2(input string tag, input logic [7:0] exp_bus,
                         input int chk_bit, input logic [1:0] chk_act);
    logic [7:0] eb;
    eb = exp_bus;
    for (int b = 7; b >= 0; b--) begin
      checkOutput($sformatf("%s bus bit%0d", tag, b), 32'(bus2), 32'(eb[b]));
      tick();
      if (b == chk_bit) begin
        checkOutput($sformatf("%s active after bit%0d", tag, b), 32'(act2), 32'(chk_act));
      end
    end
  endtask

  task automatic checkResult2(input string tag, input logic [1:0] w,
                              input logic [7:0] d, input logic c);
    checkOutput({tag, " done"}, 32'(done2), 32'd1);
    checkOutput({tag, " winner"}, 32'(win2), 32'(w));
    checkOutput({tag, " data"}, 32'(data2), 32'(d));
    checkOutput({tag, " collision"}, 32'(coll2), 32'(c));
    tick();
    checkOutput({tag, " done cleared"}, 32'(done2), 32'd0);
    checkOutput({tag, " busy cleared"}, 32'(busy2), 32'd0);
    checkOutput({tag, " winner held"}, 32'(win2), 32'(w));
    checkOutput({tag, " data held"}, 32'(data2), 32'(d));
  endtask

  initial begin
    int done_cnt;
    int busy_rise;
    logic busy_prev;

    compared   = 0;
    mismatched = 0;
    rst   = 1'b1;
    load2 = 1'b1;
    req2  = 2'b11;
    ids2  = 16'hC7E6;
    load4 = 1'b0;
    req4  = 4'h0;
    ids4  = 32'h0;

    // Reset overrides load
    tick();
    tick();
    checkOutput("reset busy", 32'(busy2), 32'd0);
    checkOutput("reset done", 32'(done2), 32'd0);
    checkOutput("reset bus_bit", 32'(bus2), 32'd1);
    checkOutput("reset active", 32'(act2), 32'd0);
    checkOutput("reset winner", 32'(win2), 32'd0);
    checkOutput("reset data", 32'(data2), 32'd0);
    checkOutput("reset collision", 32'(coll2), 32'd0);
    load2 = 1'b0;
    req2  = 2'b00;
    rst   = 1'b0;
    tick();

    $display("[TB] test 1: C7 vs E6");
    applyStimulus(2'b11, 16'hC7E6);
    checkOutput("t1 busy", 32'(busy2), 32'd1);
    runArb2("t1", 8'hC7, 5, 2'b10);
    checkResult2("t1", 2'b10, 8'hC7, 1'b0);

    $display("[TB] test 2: F3 vs EE");
    applyStimulus(2'b11, 16'hF3EE);
    runArb2("t2", 8'hEE, 4, 2'b01);
    checkResult2("t2", 2'b01, 8'hEE, 1'b0);

    $display("[TB] test 3: identical IDs");
    applyStimulus(2'b11, 16'h5555);
    runArb2("t3", 8'h55, 1, 2'b11);
    checkResult2("t3", 2'b11, 8'h55, 1'b1);

    $display("[TB] test 4: single requester, then empty request");
    applyStimulus(2'b10, 16'hFF00);
    runArb2("t4", 8'hFF, 7, 2'b10);
    checkResult2("t4", 2'b10, 8'hFF, 1'b0);
    load2 = 1'b1;
    req2  = 2'b00;
    ids2  = 16'h1234;
    tick();
    load2 = 1'b0;
    checkOutput("t4 empty load busy", 32'(busy2), 32'd0);
    done_cnt = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (done2) done_cnt++;
    end
    checkOutput("t4 empty load done count", 32'(done_cnt), 32'd0);
    checkOutput("t4 empty load keeps winner", 32'(win2), 32'(2'b10));

    $display("[TB] test 5: four nodes");
    load4 = 1'b1;
    req4  = 4'hF;
    ids4  = 32'hFF7E7F80;
    tick();
    load4 = 1'b0;
    checkOutput("t5 first bus bit", 32'(bus4), 32'd0);
    tick();
    checkOutput("t5 active after first bit", 32'(act4), 32'(4'b0110));
    for (int k = 0; k < 7; k++) tick();
    checkOutput("t5 done", 32'(done4), 32'd1);
    checkOutput("t5 winner", 32'(win4), 32'(4'b0100));
    checkOutput("t5 data", 32'(data4), 32'h7E);
    checkOutput("t5 collision", 32'(coll4), 32'd0);
    tick();

    $display("[TB] test 6a: reset mid-arbitration");
    applyStimulus(2'b11, 16'hC7E6);
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("t6 abort busy", 32'(busy2), 32'd0);
    checkOutput("t6 abort active", 32'(act2), 32'd0);
    checkOutput("t6 abort winner", 32'(win2), 32'd0);
    checkOutput("t6 abort data", 32'(data2), 32'd0);
    checkOutput("t6 abort collision", 32'(coll2), 32'd0);
    checkOutput("t6 abort bus_bit", 32'(bus2), 32'd1);
    done_cnt = 0;
    for (int k = 0; k < 12; k++) begin
      if (done2) done_cnt++;
      tick();
    end
    checkOutput("t6 abort done count", 32'(done_cnt), 32'd0);
    applyStimulus(2'b11, 16'hF3EE);
    runArb2("t6 rerun", 8'hEE, 4, 2'b01);
    checkResult2("t6 rerun", 2'b01, 8'hEE, 1'b0);

    $display("[TB] test 6b: load held high");
    load2 = 1'b1;
    req2  = 2'b11;
    ids2  = 16'hF3EE;
    done_cnt  = 0;
    busy_rise = 0;
    busy_prev = busy2;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (done2) done_cnt++;
      if (busy2 && !busy_prev) busy_rise++;
      busy_prev = busy2;
    end
    load2 = 1'b0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (done2) done_cnt++;
      if (busy2 && !busy_prev) busy_rise++;
      busy_prev = busy2;
    end
    checkOutput("t6 held load accepted", 32'(busy_rise), 32'd2);
    checkOutput("t6 held load done count", 32'(done_cnt), 32'd2);
    checkOutput("t6 held load data", 32'(data2), 32'hEE);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
